// File: rtl/seq_timer.sv
// seq_timer: sequencer-driven 16-bit down-counter with prescaler.
// Commands arrive on oreg/oreg_wen; readback via status.
module seq_timer (
  input  logic        clock,
  input  logic        reset,
  input  logic [11:0] oreg,
  input  logic        oreg_wen,
  output logic [7:0]  status,
  output logic        expire
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [3:0] CMD_NOP    = 4'h0;
  localparam logic [3:0] CMD_LDL    = 4'h1;
  localparam logic [3:0] CMD_LDH    = 4'h2;
  localparam logic [3:0] CMD_START  = 4'h3;
  localparam logic [3:0] CMD_STOP   = 4'h4;
  localparam logic [3:0] CMD_RESUME = 4'h5;
  localparam logic [3:0] CMD_PRESC  = 4'h6;
  localparam logic [3:0] CMD_MODE   = 4'h7;
  localparam logic [3:0] CMD_CLEAR  = 4'h8;
  localparam logic [3:0] CMD_SEL    = 4'h9;

  state_t      state_q, state_d;
  logic [15:0] reload_q, reload_d;
  logic [15:0] count_q, count_d;
  logic [7:0]  presc_q, presc_d;
  logic [7:0]  pcnt_q, pcnt_d;
  logic        auto_q, auto_d;
  logic        expired_q, expired_d;
  logic        error_q, error_d;
  logic [1:0]  sel_q, sel_d;
  logic        expire_q, expire_d;

  logic [3:0]  cmd;
  logic [7:0]  arg;

  assign cmd = oreg[11:8];
  assign arg = oreg[7:0];

  // state register: reset wins over any command or tick
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      reload_q  <= '0;
      count_q   <= '0;
      presc_q   <= '0;
      pcnt_q    <= '0;
      auto_q    <= 1'b0;
      expired_q <= 1'b0;
      error_q   <= 1'b0;
      sel_q     <= '0;
      expire_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      reload_q  <= reload_d;
      count_q   <= count_d;
      presc_q   <= presc_d;
      pcnt_q    <= pcnt_d;
      auto_q    <= auto_d;
      expired_q <= expired_d;
      error_q   <= error_d;
      sel_q     <= sel_d;
      expire_q  <= expire_d;
    end
  end

  // next state: a command cycle never ticks the timer
  always_comb begin
    state_d   = state_q;
    reload_d  = reload_q;
    count_d   = count_q;
    presc_d   = presc_q;
    pcnt_d    = pcnt_q;
    auto_d    = auto_q;
    expired_d = expired_q;
    error_d   = error_q;
    sel_d     = sel_q;
    expire_d  = 1'b0;
    if (oreg_wen) begin
      unique case (cmd)
        CMD_NOP: ;
        CMD_LDL: reload_d[7:0] = arg;
        CMD_LDH: reload_d[15:8] = arg;
        CMD_START: begin
          if (reload_q == 16'd0) begin
            expired_d = 1'b1;
            expire_d  = 1'b1;
            state_d   = IDLE;
          end else begin
            count_d = reload_q;
            pcnt_d  = '0;
            state_d = RUN;
          end
        end
        CMD_STOP: state_d = IDLE;
        CMD_RESUME: begin
          if (state_q == IDLE && count_q != 16'd0)
            state_d = RUN;
        end
        CMD_PRESC: presc_d = arg;
        CMD_MODE:  auto_d = arg[0];
        CMD_CLEAR: begin
          expired_d = 1'b0;
          error_d   = 1'b0;
        end
        CMD_SEL: sel_d = arg[1:0];
        default: error_d = 1'b1;
      endcase
    end else if (state_q == RUN) begin
      // >= so a prescaler lowered mid-run ticks next edge
      if (pcnt_q >= presc_q) begin
        pcnt_d = '0;
        if (count_q == 16'd1) begin
          expired_d = 1'b1;
          expire_d  = 1'b1;
          if (auto_q && reload_q != 16'd0) begin
            count_d = reload_q;
          end else begin
            count_d = '0;
            state_d = IDLE;
          end
        end else if (count_q != 16'd0) begin
          count_d = count_q - 16'd1;
        end else begin
          state_d = IDLE;
        end
      end else begin
        pcnt_d = pcnt_q + 8'd1;
      end
    end
  end

  // readback mux, registers only
  always_comb begin
    status = 8'h00;
    unique case (sel_q)
      2'd0: status = {4'b0, error_q, auto_q,
                      expired_q, state_q == RUN};
      2'd1: status = count_q[7:0];
      2'd2: status = count_q[15:8];
      2'd3: status = reload_q[7:0];
      default: status = 8'h00;
    endcase
  end

  assign expire = expire_q;

endmodule

// File: tb/tb_seq_timer.sv
// tb_seq_timer: directed checks of seq_timer.
// Inputs change and outputs are sampled on the falling edge.
module tb_seq_timer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [11:0] oreg = '0;
  logic        oreg_wen = 1'b0;
  logic [7:0]  status;
  logic        expire;

  int n_checks = 0;
  int n_err = 0;

  seq_timer dut (
    .clock    (clock),
    .reset    (reset),
    .oreg     (oreg),
    .oreg_wen (oreg_wen),
    .status   (status),
    .expire   (expire)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag,
                     input logic [15:0] obs,
                     input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  // called at a falling edge; returns one falling edge after
  // the accepting rising edge
  task automatic issue(input logic [3:0] c,
                       input logic [7:0] a);
    oreg = {c, a};
    oreg_wen = 1'b1;
    @(negedge clock);
    oreg_wen = 1'b0;
    oreg = 12'h000;
  endtask

  initial begin
    logic quiet;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    chk("reset_status", {8'h0, status}, 16'h0000);
    chk("reset_expire", {15'h0, expire}, 16'h0000);

    // writes without oreg_wen are ignored
    oreg = 12'h300;
    @(negedge clock);
    @(negedge clock);
    oreg = 12'h000;
    chk("no_wen", {8'h0, status}, 16'h0000);

    // one-shot: reload 3, presc 1 -> expiry at T+6
    issue(4'h1, 8'h03);
    issue(4'h2, 8'h00);
    issue(4'h6, 8'h01);
    issue(4'h3, 8'h00);
    chk("os_run", {8'h0, status}, 16'h0001);
    quiet = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clock);
      if (expire !== 1'b0) quiet = 1'b0;
    end
    chk("os_early", {15'h0, quiet}, 16'h0001);
    @(negedge clock);
    chk("os_expire", {15'h0, expire}, 16'h0001);
    chk("os_status", {8'h0, status}, 16'h0002);
    issue(4'h9, 8'h01);
    chk("os_pulse1", {15'h0, expire}, 16'h0000);
    chk("os_count", {8'h0, status}, 16'h0000);
    issue(4'h9, 8'h00);
    issue(4'h8, 8'h00);
    chk("clear1", {8'h0, status}, 16'h0000);

    // START with reload 0
    issue(4'h1, 8'h00);
    issue(4'h3, 8'h00);
    chk("z_expire", {15'h0, expire}, 16'h0001);
    chk("z_status", {8'h0, status}, 16'h0002);
    @(negedge clock);
    chk("z_pulse1", {15'h0, expire}, 16'h0000);
    issue(4'h8, 8'h00);
    chk("z_clear", {8'h0, status}, 16'h0000);

    // illegal command
    issue(4'hC, 8'h55);
    chk("ill_err", {8'h0, status}, 16'h0008);
    issue(4'h9, 8'h03);
    chk("ill_reload", {8'h0, status}, 16'h0000);
    issue(4'h9, 8'h00);
    issue(4'h8, 8'h00);
    chk("ill_clear", {8'h0, status}, 16'h0000);

    // auto-reload with period 2
    issue(4'h1, 8'h02);
    issue(4'h6, 8'h00);
    issue(4'h7, 8'h01);
    issue(4'h3, 8'h00);
    chk("ar_start", {8'h0, status}, 16'h0005);
    for (int p = 0; p < 3; p++) begin
      @(negedge clock);
      chk("ar_gap", {15'h0, expire}, 16'h0000);
      @(negedge clock);
      chk("ar_pulse", {15'h0, expire}, 16'h0001);
      chk("ar_status", {8'h0, status}, 16'h0007);
    end
    issue(4'h4, 8'h00);
    chk("ar_stop", {8'h0, status}, 16'h0006);
    chk("ar_nopulse", {15'h0, expire}, 16'h0000);
    issue(4'h7, 8'h00);
    issue(4'h8, 8'h00);
    chk("ar_clear", {8'h0, status}, 16'h0000);

    // stop / resume with reload 0x0100
    issue(4'h1, 8'h00);
    issue(4'h2, 8'h01);
    issue(4'h3, 8'h00);
    repeat (10) @(negedge clock);
    issue(4'h4, 8'h00);
    issue(4'h9, 8'h01);
    chk("sr_lo", {8'h0, status}, 16'h00F6);
    issue(4'h9, 8'h02);
    chk("sr_hi", {8'h0, status}, 16'h0000);
    issue(4'h9, 8'h00);
    chk("sr_idle", {8'h0, status}, 16'h0000);
    issue(4'h5, 8'h00);
    chk("sr_resume", {8'h0, status}, 16'h0001);
    quiet = 1'b1;
    for (int k = 1; k <= 245; k++) begin
      @(negedge clock);
      if (expire !== 1'b0) quiet = 1'b0;
    end
    chk("sr_early", {15'h0, quiet}, 16'h0001);
    @(negedge clock);
    chk("sr_expire", {15'h0, expire}, 16'h0001);
    chk("sr_status", {8'h0, status}, 16'h0002);
    issue(4'h8, 8'h00);

    // reset on the edge an expiry was due
    issue(4'h1, 8'h02);
    issue(4'h2, 8'h00);
    issue(4'h3, 8'h00);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("rst_expire", {15'h0, expire}, 16'h0000);
    chk("rst_status", {8'h0, status}, 16'h0000);
    reset = 1'b0;
    @(negedge clock);
    chk("rst_expire2", {15'h0, expire}, 16'h0000);
    issue(4'h9, 8'h03);
    chk("rst_reload", {8'h0, status}, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/seq_timer.md
SEQ_TIMER -- requirements
Module: seq_timer

Interface
REQ-001 SHALL have one clock; reset is synchronous and active-high.
REQ-002 SHALL have port `clock`, input, 1 bit: rising-edge clock for all state.
REQ-003 SHALL have port `reset`, input, 1 bit: synchronous active-high reset.
REQ-004 SHALL have port `oreg`, input, 12 bits: sequencer command word; [11:8] = cmd, [7:0] = arg.
REQ-005 SHALL have port `oreg_wen`, input, 1 bit: this device's one-hot write-enable bit from the sequencer; command accepted on a rising edge where it is 1.
REQ-006 SHALL have port `status`, output, 8 bits: selected readback byte, wired to a sequencer ireg input for wz/wn/jz/jn/jr.
REQ-007 SHALL have port `expire`, output, 1 bit: one-cycle pulse on each timer expiry.

Function
REQ-008 SHALL hold these internal registers: state {Idle, Run}; reload[15:0]; count[15:0]; presc[7:0]; presc_cnt[7:0]; auto; expired; error; sel[1:0].
REQ-009 SHALL decode commands as: 0 NOP; 1 LDL reload[7:0]<=arg; 2 LDH reload[15:8]<=arg; 3 START; 4 STOP; 5 RESUME; 6 PRESC presc<=arg; 7 MODE auto<=arg[0]; 8 CLEAR expired<=0, error<=0; 9 SEL sel<=arg[1:0].
REQ-010 SHALL treat command codes A-F as illegal: set error, change nothing else.
REQ-011 SHALL, on START, load count<=reload and presc_cnt<=0, and enter Run, from either state (a restart if already running).
REQ-012 SHALL, on START with reload==0, instead set expired, pulse expire on the next cycle, and enter Idle.
REQ-013 SHALL, on STOP, enter Idle and hold count and presc_cnt unchanged.
REQ-014 SHALL, on RESUME in Idle with count!=0, enter Run without clearing presc_cnt; RESUME is a no-op otherwise.
REQ-015 SHALL let LDL, LDH, PRESC, MODE and SEL take effect in either state without disturbing count, presc_cnt or state.
REQ-016 SHALL not advance the timer in any cycle in which a command is accepted, so command and tick never coincide.
REQ-017 SHALL, in Run with no command accepted: if presc_cnt==presc, set presc_cnt<=0 and decrement count; else increment presc_cnt.
REQ-018 SHALL, on a decrement from count==1 (expiry), set expired (sticky) and pulse expire for exactly the one cycle after that edge.
REQ-019 SHALL, on expiry with auto==1 and reload!=0, set count<=reload and stay in Run; otherwise set count<=0 and enter Idle.
REQ-020 SHALL have expiry latency exactly reload×(presc+1) clock edges after the START edge, with no commands in between; the auto-reload period SHALL be the same value.
REQ-021 SHALL count using unsigned modulo arithmetic; count never decrements below 0, and presc_cnt never exceeds presc.
REQ-022 SHALL take presc_cnt==presc when presc is changed below presc_cnt during Run, so the tick occurs on the next advancing edge.
REQ-023 SHALL drive `status` combinationally from registers only, never from oreg: sel=0 gives {4'b0, error, auto, expired, state==Run}; 1 gives count[7:0]; 2 gives count[15:8]; 3 gives reload[7:0].
REQ-024 SHALL make a command's effect visible on `status` in the cycle after its accepting edge.
REQ-025 SHALL ignore `oreg` entirely whenever oreg_wen==0.

Reset
REQ-026 SHALL, on reset, set state=Idle; reload, count, presc, presc_cnt, auto, expired, error and sel to 0; status=8'h00 and expire=0 from the next cycle.
REQ-027 SHALL give reset priority over any simultaneous command or tick; reset mid-Run aborts the timer with no expire pulse.

Verification
REQ-028 SHALL cover one-shot: LDL 03, LDH 00, PRESC 01, START at edge T -> expire high only after edge T+6, status=8'h02, state Idle, count 0.
REQ-029 SHALL cover auto-reload: LDL 02, PRESC 00, MODE 01, START -> expire pulses every 2 cycles, and status bit0 stays 1 until STOP.
REQ-030 SHALL cover STOP/RESUME: reload 0x0100, PRESC 00, START, STOP after 10 cycles -> SEL 1/2 reads F6/00; RESUME -> expiry 246 cycles later.
REQ-031 SHALL cover the boundary: START with reload 0 -> expired=1, expire pulse, Idle; then CLEAR -> status 8'h00.
REQ-032 SHALL cover an illegal command: cmd C -> status=8'h08 and timer unaffected; CLEAR -> bit3 cleared.
REQ-033 SHALL cover reset asserted in Run -> status 8'h00 and no expire pulse, even if expiry was due on the same edge.
